trace_dump: RTL and testbench
=============================

TRACE_DUMP -- requirements
Module: trace_dump

Interface
REQ-001 SHALL have parameter N, default 8: vector lanes per entry.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: bits per lane.
REQ-003 SHALL have parameter TB_SIZE, default 64: trace buffer depth in entries; AW = $clog2(TB_SIZE).
REQ-004 SHALL have parameter RAM_LATENCY, default 1: port-B read latency in cycles.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port dump_start, input, 1: one-cycle request to dump the buffer.
REQ-008 SHALL have port wr_ptr, input, AW: writer's next write address.
REQ-009 SHALL have port wrapped, input, 1: writer has filled all TB_SIZE entries at least once.
REQ-010 SHALL have port dump_busy, output, 1: high while dumping; the writer freezes on it.
REQ-011 SHALL have port mem_address_b, output, AW: RAM port-B address.
REQ-012 SHALL have port mem_wren_b, output, 1: RAM port-B write enable.
REQ-013 SHALL have port mem_data_b, output, N*DATA_WIDTH: RAM port-B write data.
REQ-014 SHALL have port mem_q_b, input, N*DATA_WIDTH: RAM port-B read data.
REQ-015 SHALL have port vector_out, output, [N-1:0][DATA_WIDTH-1:0]: dumped entry; lane 0 is the most significant slice of the word.
REQ-016 SHALL have port valid_out, output, 1: vector_out holds a valid entry.
REQ-017 SHALL have port ready_in, input, 1: consumer accepts the entry.
REQ-018 SHALL have port dump_done, output, 1: one-cycle pulse when a dump completes.

Function
REQ-019 SHALL use the states IDLE, READ, DRAIN and DONE.
REQ-020 SHALL, on dump_start in IDLE, latch count = wrapped ? TB_SIZE : wr_ptr and start address = wrapped ? wr_ptr : 0, assert dump_busy the next cycle, and enter READ, or enter DONE if count == 0.
REQ-021 SHALL ignore dump_start outside IDLE.
REQ-022 SHALL, in READ, issue one read per cycle while (reads in flight + skid occupancy) < 2, incrementing the address modulo TB_SIZE (TB_SIZE-1 wraps to 0), so entries leave oldest-first.
REQ-023 SHALL enter DRAIN after count reads have been issued, and leave DRAIN for DONE when no read is in flight and the skid is empty.
REQ-024 SHALL, in DONE, pulse dump_done for exactly one cycle and deassert dump_busy, then return to IDLE.
REQ-025 SHALL capture each read word exactly RAM_LATENCY cycles after its issue into a 2-entry skid buffer, so no entry is lost or duplicated under any ready_in pattern.
REQ-026 SHALL count a beat transferred when valid_out && ready_in; while valid_out && !ready_in, vector_out SHALL hold stable.
REQ-027 SHALL, with ready_in held high and the Configuration feature off, deliver one beat per cycle; the first beat appears RAM_LATENCY+1 cycles after READ entry.
REQ-028 SHALL drive mem_wren_b=0 and mem_data_b=0 when the Configuration feature is absent.

Reset
REQ-029 SHALL, on rst_n low, asynchronously force state IDLE and set every output to 0 (including mem_address_b, dump_busy, valid_out and dump_done), and empty the skid buffer and in-flight counters.
REQ-030 SHALL, on reset mid-dump, abort with no dump_done pulse; after release it SHALL accept a new dump_start.

Configuration
REQ-031 SHALL, with TRACE_DUMP_CLEAR_EN defined, follow each read issue with one clear cycle (mem_wren_b=1, mem_data_b=0, same address); max throughput is 1 beat per 2 cycles, and the buffer reads all-zero after the dump.
REQ-032 SHALL, without TRACE_DUMP_CLEAR_EN, perform a read-only dump; the buffer is left unchanged.

Structure
REQ-033 SHALL place the state enum type and the AW and word-width helper constants in the shared package trace_pkg.
REQ-034 SHALL implement the 2-entry skid buffer as sub-module trace_dump_skid (valid/ready in and out, parameter WIDTH).

Verification
REQ-035 SHALL cover: wrapped=0, wr_ptr=5, ready_in=1 -> exactly 5 beats from addresses 0..4, then one dump_done pulse.
REQ-036 SHALL cover: wrapped=1, wr_ptr=10, TB_SIZE=64 -> 64 beats from addresses 10..63 then 0..9, with the address wrapping cleanly.
REQ-037 SHALL cover: wrapped=0, wr_ptr=0 -> no valid_out, dump_done 1 cycle after dump_busy rises.
REQ-038 SHALL cover: random ready_in at 30% duty over a 64-entry dump -> all 64 entries in order, no duplicates, vector_out stable while stalled.
REQ-039 SHALL cover: rst_n low after beat 20 of 64 -> all outputs 0 at once, no dump_done; a later dump_start runs a full dump.
REQ-040 SHALL cover: TRACE_DUMP_CLEAR_EN defined, 8 entries -> 8 beats in at least 16 cycles, and a second dump returns 8 zero entries.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared state type and sizing helpers for the trace buffer dump engine.
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dump_state_e;

    // Address width for a buffer of the given depth; a depth of one still needs a bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int word_width(input int lanes, input int lane_bits);
        return lanes * lane_bits;
    endfunction

endpackage

// File: rtl/trace_dump_skid.sv
// Two-entry skid buffer: captures in the same edge as in_vld_i, output registered (0-cycle bypass none).
// Backpressure: in_rdy_o drops when both entries are full; head stays stable while out_rdy_i is low.
module trace_dump_skid #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    input  logic [WIDTH-1:0] in_dat_i,
    output logic             out_vld_o,
    input  logic             out_rdy_i,
    output logic [WIDTH-1:0] out_dat_o
);

    logic [WIDTH-1:0] ent_q [2];
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             push, pop;

    assign in_rdy_o  = (cnt_q != 2'd2);
    assign out_vld_o = (cnt_q != 2'd0);
    assign out_dat_o = ent_q[rd_sel_q];

    always_comb begin
        push     = in_vld_i && in_rdy_o;
        pop      = out_vld_o && out_rdy_i;
        wr_sel_d = push ? ~wr_sel_q : wr_sel_q;
        rd_sel_d = pop  ? ~rd_sel_q : rd_sel_q;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                ent_q[wr_sel_q] <= in_dat_i;
            end
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/trace_dump.sv
// Trace buffer dump: streams the buffer oldest-first over valid/ready, first beat RAM_LATENCY+1 cycles after READ entry.
// At most two reads outstanding (in flight + skid) so no beat is lost under stall; TRACE_DUMP_CLEAR_EN zeroes each entry after its read.
module trace_dump
    import trace_pkg::*;
#(
    parameter int N           = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int TB_SIZE     = 64,
    parameter int RAM_LATENCY = 1,
    localparam int AW         = addr_width(TB_SIZE),
    localparam int WW         = word_width(N, DATA_WIDTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           dump_start,
    input  logic [AW-1:0]                  wr_ptr,
    input  logic                           wrapped,
    output logic                           dump_busy,
    output logic [AW-1:0]                  mem_address_b,
    output logic                           mem_wren_b,
    output logic [WW-1:0]                  mem_data_b,
    input  logic [WW-1:0]                  mem_q_b,
    output logic [N-1:0][DATA_WIDTH-1:0]   vector_out,
    output logic                           valid_out,
    input  logic                           ready_in,
    output logic                           dump_done
);

`ifdef TRACE_DUMP_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    dump_state_e          state_q, state_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [AW:0]          rem_q, rem_d;
    logic [1:0]           occ_q, occ_d;
    logic                 clr_q, clr_d;
    logic [RAM_LATENCY-1:0] pipe_q, pipe_d;
    logic                 done_q;
    logic                 issue, beat;
    logic [AW-1:0]        addr_inc;
    logic                 skid_in_rdy;
    logic [WW-1:0]        skid_dat;

    assign beat     = valid_out && ready_in;
    assign addr_inc = (addr_q == AW'(TB_SIZE - 1)) ? '0 : addr_q + 1'b1;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        clr_d   = clr_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                clr_d = 1'b0;
                if (dump_start) begin
                    rem_d   = wrapped ? (AW+1)'(TB_SIZE) : {1'b0, wr_ptr};
                    addr_d  = wrapped ? wr_ptr : '0;
                    state_d = (rem_d == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (clr_q) begin
                    clr_d  = 1'b0;
                    addr_d = addr_inc;
                // A beat leaving this cycle frees its credit in time for a new read.
                end else if (rem_q != '0 && (occ_q < 2'd2 || beat)) begin
                    issue = 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (CLEAR_EN) begin
                        clr_d = 1'b1;
                    end else begin
                        addr_d = addr_inc;
                    end
                end
                if (rem_d == '0 && !clr_d) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (occ_q == 2'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        occ_d  = occ_q + {1'b0, issue} - {1'b0, beat};
        pipe_d = (pipe_q << 1) | RAM_LATENCY'(issue);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            occ_q   <= 2'd0;
            clr_q   <= 1'b0;
            pipe_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            occ_q   <= occ_d;
            clr_q   <= clr_d;
            pipe_q  <= pipe_d;
            done_q  <= (state_q == DONE);
        end
    end

    assign dump_busy     = (state_q != IDLE);
    assign dump_done     = done_q;
    assign mem_address_b = addr_q;
    assign mem_data_b    = '0;
`ifdef TRACE_DUMP_CLEAR_EN
    assign mem_wren_b    = (state_q == READ) && clr_q;
`else
    assign mem_wren_b    = 1'b0;
`endif

    trace_dump_skid #(
        .WIDTH (WW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld_i  (pipe_q[RAM_LATENCY-1]),
        .in_rdy_o  (skid_in_rdy),
        .in_dat_i  (mem_q_b),
        .out_vld_o (valid_out),
        .out_rdy_i (ready_in),
        .out_dat_o (skid_dat)
    );

    // Lane 0 sits in the most significant slice of the RAM word.
    always_comb begin
        vector_out = '0;
        for (int i = 0; i < N; i++) begin
            vector_out[i] = skid_dat[(N-1-i)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    a_credit_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        pipe_q[RAM_LATENCY-1] |-> skid_in_rdy);

endmodule

// File: tb/tb_trace_dump.sv
// Bench for trace_dump: RAM model, random ready_in, queue-based reference of the expected beat stream.
module tb_trace_dump;

    localparam int N      = 8;
    localparam int DW     = 32;
    localparam int TBS    = 64;
    localparam int AW     = 6;
    localparam int WW     = N * DW;
    localparam int BUDGET = 3000;

    typedef logic [N-1:0][DW-1:0] vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          dump_start = 1'b0;
    logic          wrapped = 1'b0;
    logic          ready_in = 1'b0;
    logic [AW-1:0] wr_ptr = '0;
    logic          dump_busy, mem_wren_b, valid_out, dump_done;
    logic [AW-1:0] mem_address_b;
    logic [WW-1:0] mem_data_b, mem_q_b;
    vec_t          vector_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    trace_dump dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dump_start    (dump_start),
        .wr_ptr        (wr_ptr),
        .wrapped       (wrapped),
        .dump_busy     (dump_busy),
        .mem_address_b (mem_address_b),
        .mem_wren_b    (mem_wren_b),
        .mem_data_b    (mem_data_b),
        .mem_q_b       (mem_q_b),
        .vector_out    (vector_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .dump_done     (dump_done)
    );

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        for (int j = 0; j < N; j++) w[j*DW +: DW] = $urandom;
        return w;
    endfunction

    // Single-port-B RAM, one cycle read latency, read-before-write.
    logic [WW-1:0] mem [TBS];
    logic [WW-1:0] snap [TBS];
    logic          load_req = 1'b0;
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < TBS; i++) mem[i] <= rand_word();
        end else if (mem_wren_b) begin
            mem[mem_address_b] <= mem_data_b;
        end
        mem_q_b <= mem[mem_address_b];
    end

    task automatic load_mem();
        @(negedge clk) load_req = 1'b1;
        @(negedge clk) load_req = 1'b0;
        snap = mem;
    endtask

    // Reference: lane i of a beat is the i-th DW slice counted from the word's MSB.
    function automatic vec_t lanes_of(input logic [WW-1:0] w);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = w[WW-1-i*DW -: DW];
        return v;
    endfunction

    vec_t exp_q[$];
    task automatic build_exp(input logic wrp, input int wp);
        int cnt, start;
        exp_q.delete();
        cnt   = wrp ? TBS : wp;
        start = wrp ? wp : 0;
        for (int k = 0; k < cnt; k++) exp_q.push_back(lanes_of(snap[(start + k) % TBS]));
    endtask

    // Observations from one dump, filled by run_dump.
    vec_t got_q[$];
    int   beat_cyc_q[$];
    int   busy_rise, done_cnt, done_cyc, stall_err, wren_seen;
    logic busy_at_done;

    task automatic run_dump(input logic wrp, input int wp, input int duty, input int abort_at);
        logic prev_stall;
        vec_t prev_vec;
        got_q.delete();
        beat_cyc_q.delete();
        busy_rise = -1; done_cnt = 0; done_cyc = -1; stall_err = 0; wren_seen = 0;
        busy_at_done = 1'b0; prev_stall = 1'b0; prev_vec = '0;
        @(negedge clk);
        dump_start = 1'b1; wrapped = wrp; wr_ptr = AW'(wp); ready_in = 1'b0;
        for (int k = 1; k < BUDGET; k++) begin
            @(negedge clk);
            dump_start = 1'b0;
            if (dump_busy && busy_rise < 0) busy_rise = k;
            if (mem_wren_b) wren_seen++;
            if (prev_stall && (!valid_out || vector_out !== prev_vec)) stall_err++;
            if (dump_done) begin
                done_cnt++;
                done_cyc = k;
                busy_at_done = dump_busy;
            end
            ready_in = ($urandom_range(99) < duty);
            if (valid_out && ready_in) begin
                got_q.push_back(vector_out);
                beat_cyc_q.push_back(k);
            end
            prev_stall = valid_out && !ready_in;
            prev_vec   = vector_out;
            if (abort_at > 0 && got_q.size() == abort_at) begin
                @(posedge clk);
                #1 rst_n = 1'b0;
                break;
            end
            if (done_cnt > 0 && k >= done_cyc + 3) break;
        end
        ready_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (dump_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", dump_busy); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid_out); end
        total++; if (dump_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", dump_done); end
        total++; if (mem_address_b !== '0) begin bad++; $display("FAIL rst_addr got=%h exp=0", mem_address_b); end
        total++; if (mem_wren_b !== 1'b0 || mem_data_b !== '0) begin bad++; $display("FAIL rst_wr got=%b/%h exp=0/0", mem_wren_b, mem_data_b); end
        total++; if (vector_out !== '0) begin bad++; $display("FAIL rst_vec got=%h exp=0", vector_out); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (dump_busy !== 1'b0 || valid_out !== 1'b0) begin bad++; $display("FAIL rst_idle got=%b%b exp=00", dump_busy, valid_out); end
    endtask

    task automatic test_short();
        load_mem();
        build_exp(1'b0, 5);
        run_dump(1'b0, 5, 100, 0);
        total++; if (got_q.size() != 5) begin bad++; $display("FAIL short_count got=%0d exp=5", got_q.size()); end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL short_beat%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
        if (got_q.size() > 0) begin
            total++; if (beat_cyc_q[0] - busy_rise != 2) begin bad++; $display("FAIL short_latency got=%0d exp=2", beat_cyc_q[0] - busy_rise); end
`ifndef TRACE_DUMP_CLEAR_EN
            total++; if (beat_cyc_q[got_q.size()-1] - beat_cyc_q[0] != got_q.size() - 1) begin
                bad++; $display("FAIL short_rate got=%0d exp=%0d", beat_cyc_q[got_q.size()-1] - beat_cyc_q[0], got_q.size() - 1);
            end
`endif
            total++; if (done_cyc <= beat_cyc_q[got_q.size()-1]) begin bad++; $display("FAIL short_done_order got=%0d exp>%0d", done_cyc, beat_cyc_q[got_q.size()-1]); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL short_done_pulses got=%0d exp=1", done_cnt); end
        total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL short_busy_at_done got=%b exp=0", busy_at_done); end
    endtask

    task automatic test_wrapped();
        load_mem();
        build_exp(1'b1, 10);
        run_dump(1'b1, 10, 100, 0);
        total++; if (got_q.size() != TBS) begin bad++; $display("FAIL wrap_count got=%0d exp=%0d", got_q.size(), TBS); end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL wrap_beat%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
`ifndef TRACE_DUMP_CLEAR_EN
        if (got_q.size() == TBS) begin
            total++; if (beat_cyc_q[TBS-1] - beat_cyc_q[0] != TBS - 1) begin bad++; $display("FAIL wrap_rate got=%0d exp=%0d", beat_cyc_q[TBS-1] - beat_cyc_q[0], TBS - 1); end
        end
`endif
        total++; if (done_cnt != 1) begin bad++; $display("FAIL wrap_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_empty();
        run_dump(1'b0, 0, 100, 0);
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL empty_count got=%0d exp=0", got_q.size()); end
        total++; if (busy_rise < 0 || done_cyc - busy_rise != 1) begin bad++; $display("FAIL empty_done_delay got=%0d exp=1", done_cyc - busy_rise); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL empty_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_random_ready();
        int wp;
        wp = $urandom_range(TBS - 1);
        load_mem();
        build_exp(1'b1, wp);
        run_dump(1'b1, wp, 30, 0);
        total++; if (got_q.size() != TBS) begin bad++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), TBS); end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL rnd_beat%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
        total++; if (stall_err != 0) begin bad++; $display("FAIL rnd_stall_stable got=%0d exp=0", stall_err); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL rnd_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        load_mem();
        run_dump(1'b1, 33, 100, 20);
        #1;
        total++; if (got_q.size() != 20) begin bad++; $display("FAIL abort_beats got=%0d exp=20", got_q.size()); end
        total++; if (dump_busy !== 1'b0 || valid_out !== 1'b0 || dump_done !== 1'b0) begin
            bad++; $display("FAIL abort_ctrl got=%b%b%b exp=000", dump_busy, valid_out, dump_done);
        end
        total++; if (mem_address_b !== '0 || vector_out !== '0 || mem_wren_b !== 1'b0) begin
            bad++; $display("FAIL abort_data got=%h/%h/%b exp=0", mem_address_b, vector_out, mem_wren_b);
        end
        pulses = done_cnt;
        repeat (2) @(negedge clk) if (dump_done) pulses++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk) if (dump_done || dump_busy) pulses++;
        total++; if (pulses != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
        load_mem();
        build_exp(1'b1, 7);
        run_dump(1'b1, 7, 100, 0);
        total++; if (got_q.size() != TBS) begin bad++; $display("FAIL redump_count got=%0d exp=%0d", got_q.size(), TBS); end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL redump_beat%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL redump_done_pulses got=%0d exp=1", done_cnt); end
    endtask

`ifdef TRACE_DUMP_CLEAR_EN
    task automatic test_clear();
        load_mem();
        build_exp(1'b0, 8);
        run_dump(1'b0, 8, 100, 0);
        total++; if (got_q.size() != 8) begin bad++; $display("FAIL clr_count got=%0d exp=8", got_q.size()); end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL clr_beat%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
        if (got_q.size() == 8) begin
            total++; if (beat_cyc_q[7] - busy_rise + 1 < 16) begin bad++; $display("FAIL clr_span got=%0d exp>=16", beat_cyc_q[7] - busy_rise + 1); end
        end
        total++; if (wren_seen != 8) begin bad++; $display("FAIL clr_writes got=%0d exp=8", wren_seen); end
        run_dump(1'b0, 8, 100, 0);
        total++; if (got_q.size() != 8) begin bad++; $display("FAIL clr2_count got=%0d exp=8", got_q.size()); end
        for (int k = 0; k < got_q.size(); k++) begin
            total++; if (got_q[k] !== '0) begin bad++; $display("FAIL clr2_beat%0d got=%h exp=0", k, got_q[k]); end
        end
    endtask
`else
    task automatic test_readonly();
        int diffs;
        load_mem();
        run_dump(1'b1, 50, 60, 0);
        diffs = 0;
        for (int i = 0; i < TBS; i++) if (mem[i] !== snap[i]) diffs++;
        total++; if (diffs != 0) begin bad++; $display("FAIL ro_mem_changed got=%0d exp=0", diffs); end
        total++; if (wren_seen != 0) begin bad++; $display("FAIL ro_writes got=%0d exp=0", wren_seen); end
        total++; if (got_q.size() != TBS) begin bad++; $display("FAIL ro_count got=%0d exp=%0d", got_q.size(), TBS); end
    endtask
`endif

    initial begin
        test_reset();
        test_short();
        test_wrapped();
        test_empty();
        test_random_ready();
        test_reset_mid();
`ifdef TRACE_DUMP_CLEAR_EN
        test_clear();
`else
        test_readonly();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
